// File: rtl/tick_scheduler_pkg.sv
// Shared types and default widths for the millisecond tick scheduler.
package tick_scheduler_pkg;

   localparam int unsigned TS_N_CH  = 4;
   localparam int unsigned TS_DLY_W = 16;
   localparam int unsigned TS_IDX_W = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } sweep_state_e;

endpackage

// File: rtl/tick_scheduler_channel.sv
// One delay channel: counter, armed flag and (with TICK_SCHED_PERIODIC_EN) reload latch.
module tick_sched_channel #(
   parameter int unsigned DLY_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [DLY_W-1:0] load_val,
   input  logic             periodic,
   input  logic             clear,
   input  logic             dec_en,
   output logic             zero_next,
   output logic             busy
);

   localparam logic [DLY_W-1:0] ONE = DLY_W'(1);

   logic [DLY_W-1:0] r_cnt;
   logic             r_busy;

`ifdef TICK_SCHED_PERIODIC_EN
   logic [DLY_W-1:0] r_reload;
   logic             r_periodic;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_reload   <= '0;
         r_periodic <= 1'b0;
      end else if (load) begin
         r_periodic <= periodic;
         // A zero delay in periodic mode runs as a 1 ms period.
         if (load_val == '0) begin
            r_cnt    <= periodic ? ONE : '0;
            r_reload <= ONE;
            r_busy   <= periodic;
         end else begin
            r_cnt    <= load_val;
            r_reload <= load_val;
            r_busy   <= 1'b1;
         end
      end else if (clear) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (dec_en && r_busy) begin
         if (r_cnt == ONE) begin
            if (r_periodic) begin
               r_cnt <= r_reload;
            end else begin
               r_cnt  <= '0;
               r_busy <= 1'b0;
            end
         end else begin
            r_cnt <= r_cnt - ONE;
         end
      end
   end
`else
   logic w_unused_periodic;
   assign w_unused_periodic = periodic;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (load) begin
         r_cnt  <= load_val;
         r_busy <= (load_val != '0);
      end else if (clear) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (dec_en && r_busy) begin
         if (r_cnt == ONE) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt - ONE;
         end
      end
   end
`endif

   assign zero_next = r_busy && (r_cnt == ONE);
   assign busy      = r_busy;

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel ms delay scheduler with a time-multiplexed decrement sweep.
// Optional auto-reload channels: define TICK_SCHED_PERIODIC_EN.
module tick_scheduler
   import tick_scheduler_pkg::*;
#(
   parameter int unsigned N_CH  = TS_N_CH,
   parameter int unsigned DLY_W = TS_DLY_W,
   parameter int unsigned IDX_W = TS_IDX_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tick_1ms,
   input  logic [N_CH-1:0]       start,
   input  logic [N_CH-1:0]       cancel,
   input  logic [N_CH*DLY_W-1:0] delay_ms,
   input  logic [N_CH-1:0]       periodic,
   output logic [N_CH-1:0]       busy,
   output logic [N_CH-1:0]       done,
   output logic                  overrun
);

   sweep_state_e     r_state;
   logic [IDX_W-1:0] r_idx;
   logic             r_pending;
   logic             r_overrun;
   logic [N_CH-1:0]  r_done;

   logic [N_CH-1:0]  w_visit;
   logic [N_CH-1:0]  w_load_zero;
   logic [N_CH-1:0]  w_clear;
   logic [N_CH-1:0]  w_zero_next;
   logic [N_CH-1:0]  w_busy;

   // A strobe on the channel under the sweep wins; that channel skips this tick.
   always_comb begin
      w_visit     = '0;
      w_load_zero = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         w_visit[i] = (r_state == ST_SWEEP) && (r_idx == IDX_W'(i))
                      && !start[i] && !cancel[i];
`ifdef TICK_SCHED_PERIODIC_EN
         w_load_zero[i] = start[i] && !periodic[i]
                          && (delay_ms[i*DLY_W +: DLY_W] == '0);
`else
         w_load_zero[i] = start[i] && (delay_ms[i*DLY_W +: DLY_W] == '0);
`endif
      end
   end

   assign w_clear = cancel & ~start;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      tick_sched_channel #(
         .DLY_W (DLY_W)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (start[g]),
         .load_val  (delay_ms[g*DLY_W +: DLY_W]),
         .periodic  (periodic[g]),
         .clear     (w_clear[g]),
         .dec_en    (w_visit[g]),
         .zero_next (w_zero_next[g]),
         .busy      (w_busy[g])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= '0;
      end else begin
         r_done <= w_load_zero | (w_visit & w_zero_next);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_idx     <= '0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // A fresh tick arriving while a pending one is consumed stays pending.
               if (tick_1ms || r_pending) begin
                  r_state   <= ST_SWEEP;
                  r_idx     <= '0;
                  r_pending <= tick_1ms && r_pending;
               end
            end
            ST_SWEEP: begin
               if (tick_1ms) begin
                  if (r_pending) begin
                     r_overrun <= 1'b1;
                  end else begin
                     r_pending <= 1'b1;
                  end
               end
               if (r_idx == IDX_W'(N_CH - 1)) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy    = w_busy;
   assign done    = r_done;
   assign overrun = r_overrun;

endmodule
